// File: rtl/output_gain_stage.sv
// Master gain stage between the EQ and the I2S transmitter: ramped gain with mute,
// saturating scale, DAC word formatting and a clip indicator with hold time.
module output_gain_stage #(
  parameter int RAMP_STEP = 64,
  parameter int CLIP_HOLD = 4800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        l_r_clk,
  input  logic [15:0] audio_in,
  input  logic [15:0] gain_target,
  input  logic        mute,
  output logic [31:0] dac_data,
  output logic        sample_valid,
  output logic        clip,
  output logic [15:0] gain_cur
);

  localparam int CW = $clog2(CLIP_HOLD + 1);
  localparam logic [16:0] STEP17 = 17'(RAMP_STEP);

  logic        ws_q;
  logic        tick;

  logic [15:0] gain_reg;
  logic [15:0] gain_next;
  logic [15:0] tgt;
  logic [16:0] up_sum;
  logic [16:0] dn_floor;

  logic               s0_valid_reg;
  logic signed [15:0] s0_audio_reg;
  logic [15:0]        s0_gain_reg;

  logic signed [32:0] prod;
  logic signed [32:0] shifted;
  logic [15:0]        sat_sample;
  logic               sat_flag;

  logic        s1_valid_reg;
  logic [15:0] s1_sample_reg;
  logic        s1_sat_reg;

  logic [31:0]   dac_reg;
  logic          sample_valid_reg;
  logic [CW-1:0] clip_cnt_reg;

  // ws_q resets high so a word select already high at reset release is not an edge
  assign tick = l_r_clk & ~ws_q;

  // 17-bit arithmetic keeps the ramp from wrapping past 0xFFFF or below 0
  always_comb begin
    tgt       = mute ? 16'h0000 : gain_target;
    up_sum    = {1'b0, gain_reg} + STEP17;
    dn_floor  = {1'b0, tgt} + STEP17;
    gain_next = gain_reg;
    if (gain_reg < tgt) begin
      if (up_sum >= {1'b0, tgt}) gain_next = tgt;
      else                       gain_next = up_sum[15:0];
    end else if (gain_reg > tgt) begin
      if ({1'b0, gain_reg} <= dn_floor) gain_next = tgt;
      else                              gain_next = gain_reg - STEP17[15:0];
    end
  end

  // Signed audio times unsigned Q2.14 gain; >>> floors toward minus infinity
  always_comb begin
    prod       = 33'(s0_audio_reg) * 33'($signed({1'b0, s0_gain_reg}));
    shifted    = prod >>> 14;
    sat_sample = shifted[15:0];
    sat_flag   = 1'b0;
    if (shifted > 33'sd32767) begin
      sat_sample = 16'h7FFF;
      sat_flag   = 1'b1;
    end else if (shifted < -33'sd32768) begin
      sat_sample = 16'h8000;
      sat_flag   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ws_q             <= 1'b1;
      gain_reg         <= '0;
      s0_valid_reg     <= 1'b0;
      s0_audio_reg     <= '0;
      s0_gain_reg      <= '0;
      s1_valid_reg     <= 1'b0;
      s1_sample_reg    <= '0;
      s1_sat_reg       <= 1'b0;
      dac_reg          <= '0;
      sample_valid_reg <= 1'b0;
      clip_cnt_reg     <= '0;
    end else begin
      ws_q         <= l_r_clk;
      s0_valid_reg <= tick;
      if (tick) begin
        // the sample uses the gain in effect before this tick's ramp step
        s0_audio_reg <= audio_in;
        s0_gain_reg  <= gain_reg;
        gain_reg     <= gain_next;
      end

      s1_valid_reg <= s0_valid_reg;
      if (s0_valid_reg) begin
        s1_sample_reg <= sat_sample;
        s1_sat_reg    <= sat_flag;
      end

      sample_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) dac_reg <= {8'h00, s1_sample_reg, 8'h00};

      // a fresh saturation reload takes priority over the per-tick countdown
      if (s1_valid_reg && s1_sat_reg)      clip_cnt_reg <= CW'(CLIP_HOLD);
      else if (tick && clip_cnt_reg != '0) clip_cnt_reg <= clip_cnt_reg - CW'(1);
    end
  end

  assign dac_data     = dac_reg;
  assign sample_valid = sample_valid_reg;
  assign clip         = (clip_cnt_reg != '0);
  assign gain_cur     = gain_reg;

endmodule

// File: tb/tb_output_gain_stage.sv
// Scoreboard bench for output_gain_stage: behavioural model of ramp, scaling and
// clip hold; a separate monitor checks every sample_valid against queued words.
module tb_output_gain_stage;

  localparam int RAMP      = 64;
  localparam int HOLD      = 4800;

  logic        clk = 1'b0;
  logic        reset;
  logic        l_r_clk;
  logic [15:0] audio_in;
  logic [15:0] gain_target;
  logic        mute;
  logic [31:0] dac_data;
  logic        sample_valid;
  logic        clip;
  logic [15:0] gain_cur;

  int checks = 0;
  int errors = 0;
  int valid_count = 0;
  int model_gain = 0;
  int model_clip = 0;
  logic [31:0] exp_q[$];

  output_gain_stage #(.RAMP_STEP(RAMP), .CLIP_HOLD(HOLD)) dut (
    .clk(clk), .reset(reset), .l_r_clk(l_r_clk), .audio_in(audio_in),
    .gain_target(gain_target), .mute(mute), .dac_data(dac_data),
    .sample_valid(sample_valid), .clip(clip), .gain_cur(gain_cur)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding expected word
  always @(negedge clk) begin
    if (sample_valid) begin
      valid_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got dac 0x%08h with no sample outstanding", dac_data);
      end else begin
        chk("dac_data", dac_data, exp_q.pop_front());
      end
    end
  end

  // One word-select frame: low for a cycle, then high for hi cycles.
  task automatic do_tick(input logic [15:0] a, input logic [15:0] gt, input logic m, input int hi);
    longint p, s;
    int     tgt;
    bit     sat;
    logic [15:0] s16;
    @(negedge clk);
    l_r_clk = 1'b0; audio_in = a; gain_target = gt; mute = m;
    @(negedge clk);
    l_r_clk = 1'b1;
    p = longint'($signed(a)) * longint'(model_gain);
    s = (p >= 0) ? p / 16384 : -((-p + 16383) / 16384);
    sat = 1'b0;
    if (s > 32767)  begin s = 32767;  sat = 1'b1; end
    if (s < -32768) begin s = -32768; sat = 1'b1; end
    s16 = 16'(s);
    exp_q.push_back({8'h00, s16, 8'h00});
    tgt = m ? 0 : int'(gt);
    if (model_gain < tgt)      model_gain = (model_gain + RAMP > tgt) ? tgt : model_gain + RAMP;
    else if (model_gain > tgt) model_gain = (model_gain - RAMP < tgt) ? tgt : model_gain - RAMP;
    if (model_clip > 0) model_clip--;
    @(negedge clk);
    chk("gain_cur", gain_cur, model_gain);
    chk("clip", clip, model_clip != 0);
    if (sat) model_clip = HOLD;
    repeat (hi - 1) @(negedge clk);
  endtask

  task automatic ticks(input int n, input logic [15:0] a, input logic [15:0] gt, input logic m);
    for (int i = 0; i < n; i++) do_tick(a, gt, m, 2);
  endtask

  // Tick, then look at the word presented in the sample_valid cycle
  task automatic tick_out(input string name, input logic [15:0] a, input logic [15:0] gt, input logic [31:0] exp);
    do_tick(a, gt, 1'b0, 2);
    @(negedge clk);
    chk(name, dac_data, exp);
    chk({name, "_valid"}, sample_valid, 1'b1);
  endtask

  initial begin
    int vc;
    reset = 1'b1; l_r_clk = 1'b1; audio_in = 16'h1234; gain_target = 16'h4000; mute = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_dac", dac_data, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_clip", clip, 0);
    chk("rst_gain", gain_cur, 0);

    // Released with word select high, then a falling edge: neither is a tick
    repeat (100) @(negedge clk);
    chk("no_tick_at_release", gain_cur, 0);
    l_r_clk = 1'b0;
    repeat (5) @(negedge clk);
    chk("no_tick_on_fall", gain_cur, 0);
    chk("no_valid_yet", valid_count, 0);

    // Held high for 100 cycles counts once
    do_tick(16'h1234, 16'h4000, 1'b0, 100);
    chk("first_tick_gain", gain_cur, 16'h0040);
    chk("one_tick_one_valid", valid_count, 1);

    ticks(255, 16'h1234, 16'h4000, 1'b0);
    chk("unity_after_256", gain_cur, 16'h4000);
    tick_out("pass_through", 16'h1234, 16'h4000, 32'h0012_3400);

    // Saturation and clip hold
    ticks(256, 16'h0100, 16'h8000, 1'b0);
    chk("gain_8000", gain_cur, 16'h8000);
    tick_out("sat_pos", 16'h5000, 16'h8000, 32'h007F_FF00);
    chk("clip_within_3", clip, 1);
    tick_out("sat_neg", 16'hB000, 16'h8000, 32'h0080_0000);
    for (int i = 1; i <= HOLD; i++) begin
      do_tick(16'h0100, 16'h8000, 1'b0, 2);
      if (i == HOLD - 1) chk("clip_held", clip, 1);
      if (i == HOLD)     chk("clip_released", clip, 0);
    end

    // Floor arithmetic at half gain
    ticks(384, 16'h0100, 16'h2000, 1'b0);
    chk("gain_2000", gain_cur, 16'h2000);
    tick_out("floor_neg", 16'hFFFD, 16'h2000, 32'h00FF_FE00);
    tick_out("floor_pos", 16'h0003, 16'h2000, 32'h0000_0100);

    // Mute ramp-down, silence, and small step without overshoot
    ticks(128, 16'h0100, 16'h4000, 1'b0);
    ticks(256, 16'h0100, 16'h4000, 1'b1);
    chk("muted_gain", gain_cur, 0);
    do_tick(16'h7FFF, 16'h4000, 1'b1, 2);
    @(negedge clk);
    chk("muted_out", dac_data, 0);
    ticks(256, 16'h0100, 16'h4000, 1'b0);
    do_tick(16'h0100, 16'h4010, 1'b0, 2);
    chk("no_overshoot", gain_cur, 16'h4010);

    // Randomized frames
    for (int i = 0; i < 300; i++) begin
      logic [15:0] gt;
      int g;
      if ($urandom_range(0, 1) == 1) begin
        g = model_gain + int'($urandom_range(0, 400)) - 200;
        if (g < 0) g = 0;
        if (g > 65535) g = 65535;
        gt = 16'(g);
      end else begin
        gt = 16'($urandom);
      end
      do_tick(16'($urandom), gt, ($urandom_range(0, 7) == 0), int'($urandom_range(2, 5)));
    end
    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    // Reset one cycle after a tick drops the in-flight sample
    @(negedge clk);
    l_r_clk = 1'b0; audio_in = 16'h7000; gain_target = 16'h4000; mute = 1'b0;
    @(negedge clk);
    l_r_clk = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    vc = valid_count;
    @(negedge clk);
    reset = 1'b0;
    model_gain = 0; model_clip = 0; exp_q.delete();
    chk("midrst_dac", dac_data, 0);
    chk("midrst_valid", sample_valid, 0);
    chk("midrst_clip", clip, 0);
    chk("midrst_gain", gain_cur, 0);
    repeat (10) @(negedge clk);
    chk("midrst_no_pulse", valid_count, vc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
